// File: rtl/mult_seq.sv
// mult_seq: sequential multiply-accumulate over one window of TAPS
// pixel/coefficient pairs. A single shared 16x16 multiplier is used for
// every tap, and the window sum is handed out through a valid/ready port.
//
// Optional feature macro: MULT_PIPE_EN
//   undefined : each product is added on the same edge that accepts its pair.
//   defined   : the multiplier output is registered first and added one cycle
//               later. The DRAIN state adds the final registered product, so
//               out_valid arrives one cycle later than in the default build.

// 16x16 unsigned multiplier shared by all taps of a window
module mult16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    assign p = 32'(a) * 32'(b);
endmodule

module mult_seq #(
    parameter int TAPS  = 9,
    parameter int ACC_W = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_pix,
    input  logic [15:0]      in_coef,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [3:0]       tap_cnt
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [3:0]       cnt;
    logic [31:0]      prod;
    logic             accept;
    logic             last;

    mult16 u_mult (.a(in_pix), .b(in_coef), .p(prod));

    assign accept    = in_valid && (state == ACCUM);
    assign last      = accept && (cnt == 4'(TAPS - 1));
    assign busy      = (state != IDLE);
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign out_acc   = acc;
    assign tap_cnt   = cnt;

`ifdef MULT_PIPE_EN
    logic [31:0] prod_q;
    logic        prod_v;

    // Capture each accepted product; prod_v marks it as waiting to be added
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            prod_v <= 1'b0;
        end else begin
            prod_v <= accept;
            if (accept)
                prod_q <= prod;
        end
    end
`endif

    // Window control FSM and accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ACCUM;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                ACCUM: begin
`ifdef MULT_PIPE_EN
                    // Product of the previous accept lands one cycle late
                    if (prod_v)
                        acc <= acc + ACC_W'(prod_q);
`else
                    if (accept)
                        acc <= acc + ACC_W'(prod);
`endif
                    if (accept) begin
                        cnt <= cnt + 4'd1;
`ifdef MULT_PIPE_EN
                        if (last) state <= DRAIN;
`else
                        if (last) state <= DONE;
`endif
                    end
                end
                DRAIN: begin
`ifdef MULT_PIPE_EN
                    if (prod_v)
                        acc <= acc + ACC_W'(prod_q);
`endif
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        if (start) begin
                            state <= ACCUM;
                            acc   <= '0;
                            cnt   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq.sv
// Directed + randomized bench for mult_seq. The reference sum of each window
// is computed with plain 64-bit arithmetic reduced modulo 2^ACC_W.
module tb_mult_seq;
    localparam int TAPS  = 9;
    localparam int ACC_W = 36;
`ifdef MULT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             busy;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_pix = '0;
    logic [15:0]      in_coef = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_acc;
    logic [3:0]       tap_cnt;

    int total = 0;
    int bad   = 0;

    logic [63:0] mask = (64'd1 << ACC_W) - 64'd1;
    logic [15:0] pa [TAPS];
    logic [15:0] ca [TAPS];
    logic [63:0] held;

    mult_seq #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
        .in_coef(in_coef), .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .tap_cnt(tap_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [15:0] p, input logic [15:0] c);
        for (int i = 0; i < TAPS; i++) begin
            pa[i] = p;
            ca[i] = c;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".out_acc"}, 64'(out_acc), 64'd0);
        chk({tag, ".tap_cnt"}, 64'(tap_cnt), 64'd0);
    endtask

    // gapmode: 0 back-to-back, 1 one idle cycle before each pair, 2 random gaps
    task automatic run_window(input string tag, input bit do_start, input int gapmode);
        logic [63:0] exp;
        int lat;
        int gaps;
        exp = 64'd0;
        for (int i = 0; i < TAPS; i++)
            exp = exp + 64'(pa[i]) * 64'(ca[i]);
        exp = exp & mask;
        if (do_start) begin
            start = 1'b1;
            step();
            start = 1'b0;
            chk({tag, ".start_ready"}, 64'(in_ready), 64'd1);
            chk({tag, ".start_acc"}, 64'(out_acc), 64'd0);
        end
        for (int i = 0; i < TAPS; i++) begin
            gaps = (gapmode == 1) ? 1 : (gapmode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gaps; g++) begin
                in_valid = 1'b0;
                in_pix   = 16'($urandom);
                step();
                chk({tag, ".stall_cnt"}, 64'(tap_cnt), 64'(i));
            end
            in_valid = 1'b1;
            in_pix   = pa[i];
            in_coef  = ca[i];
            step();
            chk({tag, ".cnt"}, 64'(tap_cnt), 64'(i + 1));
        end
        in_valid = 1'b0;
        chk({tag, ".ready_drop"}, 64'(in_ready), 64'd0);
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(LAT));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".acc"}, 64'(out_acc), exp);
        chk({tag, ".taps"}, 64'(tap_cnt), 64'(TAPS));
    endtask

    task automatic release_to_idle(input string tag);
        held = 64'(out_acc);
        out_ready = 1'b1;
        start     = 1'b0;
        step();
        out_ready = 1'b0;
        chk({tag, ".idle_busy"}, 64'(busy), 64'd0);
        chk({tag, ".idle_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".idle_acc"}, 64'(out_acc), held);
    endtask

    initial begin
        // Reset state before any clock edge
        #2;
        chk_zero("reset");
        step();
        rst_n = 1'b1;
        step();
        chk_zero("post_reset");

        // 9 x (6425 x 65535)
        fill(16'd6425, 16'd65535);
        run_window("w6425", 1'b1, 0);
        chk("w6425.const", 64'(out_acc), 64'd3789561375);
        release_to_idle("w6425");
        step();
        chk("persist", 64'(out_acc), 64'd3789561375);

        // Full-scale operands, no wrap at ACC_W=36
        fill(16'hFFFF, 16'hFFFF);
        run_window("wmax", 1'b1, 0);
        chk("wmax.const", 64'(out_acc), 64'd38653526025);
        release_to_idle("wmax");

        // 3 x 2 with alternate-cycle stalls
        fill(16'd3, 16'd2);
        run_window("wgap", 1'b1, 1);
        chk("wgap.const", 64'(out_acc), 64'd54);

        // Hold in DONE with start pulses; nothing may change
        held = 64'(out_acc);
        for (int k = 0; k < 5; k++) begin
            start = k[0];
            step();
            chk("hold.valid", 64'(out_valid), 64'd1);
            chk("hold.acc", 64'(out_acc), held);
            chk("hold.ready", 64'(in_ready), 64'd0);
        end
        start = 1'b0;
        release_to_idle("hold");

        // Back-to-back windows: restart directly from DONE
        fill(16'd2, 16'd5);
        run_window("b2b_a", 1'b1, 0);
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("b2b.valid", 64'(out_valid), 64'd0);
        chk("b2b.ready", 64'(in_ready), 64'd1);
        chk("b2b.acc", 64'(out_acc), 64'd0);
        chk("b2b.cnt", 64'(tap_cnt), 64'd0);
        fill(16'd1, 16'd1);
        run_window("b2b_b", 1'b0, 0);
        chk("b2b_b.const", 64'(out_acc), 64'd9);
        release_to_idle("b2b_b");

        // Random windows against the arithmetic model
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < TAPS; i++) begin
                pa[i] = 16'($urandom);
                ca[i] = 16'($urandom);
            end
            run_window("rand", 1'b1, 2);
            release_to_idle("rand");
        end

        // Asynchronous reset mid-window
        fill(16'd7, 16'd9);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pix   = pa[i];
            in_coef  = ca[i];
            step();
        end
        in_valid = 1'b0;
        chk("midrst.pre_cnt", 64'(tap_cnt), 64'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        step();
        rst_n = 1'b1;
        step();
        chk_zero("midrst_rel");
        fill(16'd1, 16'd1);
        run_window("after_rst", 1'b1, 0);
        chk("after_rst.const", 64'(out_acc), 64'd9);
        release_to_idle("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have parameter TAPS, default 9: number of pixel/coefficient products per window, legal range 1..15.
REQ-002 SHALL have parameter ACC_W, default 36: accumulator and result width, minimum 32.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  begins a window; honoured only in IDLE, or in DONE when out_ready=1.
REQ-006 SHALL have port busy  output  1  high in every state except IDLE.
REQ-007 SHALL have port in_valid  input  1  in_pix/in_coef valid.
REQ-008 SHALL have port in_ready  output  1  high only in ACCUM; a pair is accepted when in_valid=1 and in_ready=1.
REQ-009 SHALL have port in_pix  input  16  unsigned pixel operand.
REQ-010 SHALL have port in_coef  input  16  unsigned coefficient operand.
REQ-011 SHALL have port out_valid  output  1  high only in DONE.
REQ-012 SHALL have port out_ready  input  1  result consumer ready.
REQ-013 SHALL have port out_acc  output  ACC_W  window sum of products.
REQ-014 SHALL have port tap_cnt  output  4  pairs accepted in the current window.

Function
REQ-015 SHALL instantiate one mult16 (16x16 unsigned, 32-bit product) and share it across all taps of a window.
REQ-016 SHALL implement states IDLE, ACCUM, DRAIN and DONE.
REQ-017 IDLE: start=1 -> ACCUM; the accumulator and tap_cnt clear on the same edge.
REQ-018 ACCUM: each accepted pair adds the zero-extended 32-bit product to the accumulator; tap_cnt increments on the same edge.
REQ-019 ACCUM: in_valid=0 cycles SHALL stall without changing the accumulator or tap_cnt; there is no timeout.
REQ-020 ACCUM: acceptance of pair TAPS -> DONE, or -> DRAIN when MULT_PIPE_EN is defined; in_ready SHALL be 0 from the next cycle.
REQ-021 DRAIN: lasts exactly one cycle, adds the final registered product, then -> DONE.
REQ-022 DONE: out_valid=1 and out_acc held stable until out_ready=1.
REQ-023 DONE: out_ready=1 with start=0 -> IDLE.
REQ-024 DONE: out_ready=1 with start=1 -> ACCUM with the accumulator cleared; out_valid deasserts, giving back-to-back windows.
REQ-025 start SHALL be ignored in ACCUM and DRAIN, and in DONE while out_ready=0.
REQ-026 out_acc SHALL equal the accumulator at all times, so its value persists in IDLE until the next start.
REQ-027 Accumulation SHALL wrap modulo 2^ACC_W without a flag; with the default parameters no overflow is possible.
REQ-028 Latency from the edge accepting the last pair to out_valid=1 SHALL be 1 cycle, or 2 cycles with MULT_PIPE_EN.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, accumulator 0, tap_cnt 0, busy 0, in_ready 0 and out_valid 0, and clear any pipeline product register.
REQ-030 Reset mid-window SHALL discard the partial sum; the first clock edge after release SHALL be treated as IDLE.

Configuration
REQ-031 SHALL support macro MULT_PIPE_EN; when defined, the mult16 output is registered before the adder, the DRAIN state is used, and latency follows REQ-028.
REQ-032 Without MULT_PIPE_EN, the product SHALL add combinationally on the accept edge, DRAIN SHALL be unreachable, and results SHALL be identical to the pipelined build.

Verification
REQ-033 Default parameters; 9 pairs of 6425 x 65535 streamed back-to-back -> out_acc=3789561375, tap_cnt=9, out_valid asserted with the REQ-028 latency.
REQ-034 9 pairs of 65535 x 65535 -> out_acc=38653526025, with no wrap.
REQ-035 Window of 3 x 2 on all taps, with in_valid low on alternate cycles -> out_acc=54 and tap_cnt advances only on accepts.
REQ-036 out_ready held low 5 cycles in DONE, with start pulsed during those cycles -> out_acc stable, start ignored; out_ready=1 with start=0 -> IDLE.
REQ-037 out_ready=1 with start=1 in DONE -> next window begins the following cycle with accumulator 0; a second window of 9 x (1 x 1) -> out_acc=9.
REQ-038 rst_n pulsed low after 4 accepts -> all outputs 0 asynchronously; a new start and 9 x (1 x 1) -> out_acc=9.
